// File: rtl/cond_pkg.sv
// Shared condition codes, flag indices and IT sequencer state for the condition logic.
package cond_pkg;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   // Bit positions inside the {N,Z,C,V} flag vector
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   // Flipping this bit of a condition code yields its inverse (except AL/NV)
   localparam int unsigned COND_INV_BIT = 0;

   typedef enum logic {
      IT_IDLE   = 1'b0,
      IT_ACTIVE = 1'b1
   } it_state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator against the {N,Z,C,V} flags.
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       cond_ex
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   // Standard condition table; NV is a true never
   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         COND_EQ: cond_ex = z;
         COND_NE: cond_ex = ~z;
         COND_CS: cond_ex = c;
         COND_CC: cond_ex = ~c;
         COND_MI: cond_ex = n;
         COND_PL: cond_ex = ~n;
         COND_VS: cond_ex = v;
         COND_VC: cond_ex = ~v;
         COND_HI: cond_ex = c & ~z;
         COND_LS: cond_ex = ~c | z;
         COND_GE: cond_ex = ~(n ^ v);
         COND_LT: cond_ex = n ^ v;
         COND_GT: cond_ex = ~z & ~(n ^ v);
         COND_LE: cond_ex = z | (n ^ v);
         COND_AL: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

endmodule

// File: rtl/condlogic_it.sv
// Condition logic with grouped flag writes and an IT-block predication sequencer.
module condlogic_it
   import cond_pkg::*;
#(
   parameter int unsigned IT_DEPTH  = 4,
   parameter int unsigned FLAGW_GRP = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [3:0]                  Cond,
   input  logic [3:0]                  ALUFlags,
   input  logic [FLAGW_GRP-1:0]        FlagW,
   input  logic                        PCS,
   input  logic                        NextPC,
   input  logic                        RegW,
   input  logic                        MemW,
   input  logic                        InstrRetire,
   input  logic                        ITStart,
   input  logic [3:0]                  ITFirstCond,
   input  logic [IT_DEPTH-1:0]         ITMask,
   input  logic [$clog2(IT_DEPTH):0]   ITLen,
   output logic                        PCWrite,
   output logic                        RegWrite,
   output logic                        MemWrite,
   output logic [3:0]                  Flags,
   output logic                        InIT,
   output logic [3:0]                  ITCond,
   output logic                        ITErr
);

   localparam int unsigned CNTW = $clog2(IT_DEPTH) + 1;
   localparam int unsigned GRPW = 4 / FLAGW_GRP;

   it_state_t             state_q, state_d;
   logic [CNTW-1:0]       count_q, count_d;
   logic [CNTW-1:0]       index_q, index_d;
   logic [3:0]            base_q, base_d;
   logic [IT_DEPTH-1:0]   mask_q, mask_d;
   logic [3:0]            itcond_q, itcond_d;
   logic                  iterr_q, iterr_d;
   logic [3:0]            flags_q, flags_d;
   logic                  condexr_q, condexr_d;

   logic [3:0]            eff_cond;
   logic                  cond_ex;
   logic [CNTW-1:0]       next_idx;
   logic [CNTW-1:0]       count_dec;
   logic                  mask_bit;
   logic [3:0]            next_itcond;
   logic                  branch_taken;

   assign InIT     = (state_q == IT_ACTIVE);
   assign eff_cond = InIT ? itcond_q : Cond;

   cond_eval u_eval (
      .cond    (eff_cond),
      .flags   (flags_q),
      .cond_ex (cond_ex)
   );

   // Flag groups load from the ALU only when their instruction passes its condition
   always_comb begin
      flags_d   = flags_q;
      condexr_d = cond_ex;
      for (int g = 0; g < int'(FLAGW_GRP); g++) begin
         if (FlagW[g] && cond_ex)
            flags_d[g*GRPW +: GRPW] = ALUFlags[g*GRPW +: GRPW];
      end
   end

   // Condition of the next predicated instruction; AL never inverts
   always_comb begin
      next_idx  = index_q + CNTW'(1);
      count_dec = count_q - CNTW'(1);
      mask_bit  = 1'b0;
      for (int k = 0; k < int'(IT_DEPTH); k++) begin
         if (CNTW'(k) == next_idx)
            mask_bit = mask_q[k];
      end
      if (base_q == COND_AL)
         next_itcond = base_q;
      else
         next_itcond = {base_q[3:1], base_q[COND_INV_BIT] ^ ~mask_bit};
      branch_taken = PCS & condexr_q;
   end

   // IT sequencer next-state logic
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      index_d  = index_q;
      base_d   = base_q;
      mask_d   = mask_q;
      itcond_d = itcond_q;
      iterr_d  = 1'b0;
      case (state_q)
         IT_IDLE: begin
            if (InstrRetire && ITStart) begin
               if (ITLen == '0) begin
                  iterr_d = 1'b1;
               end else begin
                  state_d  = IT_ACTIVE;
                  count_d  = (ITLen > CNTW'(IT_DEPTH)) ? CNTW'(IT_DEPTH) : ITLen;
                  index_d  = '0;
                  base_d   = ITFirstCond;
                  mask_d   = ITMask;
                  itcond_d = ITFirstCond;
               end
            end
         end
         IT_ACTIVE: begin
            if (InstrRetire) begin
               if (ITStart)
                  iterr_d = 1'b1;
               if ((count_dec == '0) || branch_taken) begin
                  state_d  = IT_IDLE;
                  count_d  = '0;
                  index_d  = '0;
                  itcond_d = '0;
               end else begin
                  count_d  = count_dec;
                  index_d  = next_idx;
                  itcond_d = next_itcond;
               end
            end
         end
         default: state_d = IT_IDLE;
      endcase
   end

   // State, flag and condition registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IT_IDLE;
         count_q   <= '0;
         index_q   <= '0;
         base_q    <= '0;
         mask_q    <= '0;
         itcond_q  <= '0;
         iterr_q   <= 1'b0;
         flags_q   <= '0;
         condexr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         index_q   <= index_d;
         base_q    <= base_d;
         mask_q    <= mask_d;
         itcond_q  <= itcond_d;
         iterr_q   <= iterr_d;
         flags_q   <= flags_d;
         condexr_q <= condexr_d;
      end
   end

   assign Flags    = flags_q;
   assign ITCond   = itcond_q;
   assign ITErr    = iterr_q;
   assign RegWrite = RegW & condexr_q;
   assign MemWrite = MemW & condexr_q;
   assign PCWrite  = (PCS & condexr_q) | NextPC;

endmodule

// File: doc/condlogic_it.md
Name: condlogic_it

Overview:
Parametrised successor to the multi-cycle controller's condition logic.
- Holds the NZCV flag register with grouped write enables.
- Evaluates the condition code and registers CondEx for the write-back states.
- Gates RegWrite, MemWrite and PCWrite.
- Adds an IT-block sequencer: one IT instruction predicates up to IT_DEPTH following instructions, each with the base condition or its inverse.
- Sits between the main decoder/FSM and the datapath enables.

Parameters:
IT_DEPTH, 4, maximum instructions covered by one IT block; legal range 1..8.
FLAGW_GRP, 2, number of flag write groups; legal values 1, 2, 4. Each group covers 4/FLAGW_GRP flag bits, MSB group first.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
Cond  in  4  condition field of the current instruction
ALUFlags  in  4  {N,Z,C,V} from the ALU
FlagW  in  FLAGW_GRP  per-group flag write request
PCS, NextPC, RegW, MemW  in  1 each  unconditioned write requests from the decoder/FSM
InstrRetire  in  1  one-cycle strobe in the final state of each instruction
ITStart  in  1  the retiring instruction is an IT instruction; qualified by InstrRetire
ITFirstCond  in  4  base condition of the IT block
ITMask  in  IT_DEPTH  bit k: instruction k of the block uses the base condition (1) or its inverse (0); bit 0 is ignored (first is always base)
ITLen  in  $clog2(IT_DEPTH)+1  number of predicated instructions
PCWrite, RegWrite, MemWrite  out  1 each  conditioned write enables
Flags  out  4  current flag register
InIT  out  1  IT block active
ITCond  out  4  condition applied to the current instruction while InIT
ITErr  out  1  one-cycle pulse on an illegal IT request

Behaviour:
- Reset: Flags=0, CondExR=0, state IDLE, ITCond=0, index=0, ITErr=0. Outputs therefore reset to PCWrite=NextPC, RegWrite=0, MemWrite=0, InIT=0.
- EffCond = InIT ? ITCond : Cond.
- CondEx is combinational from EffCond and Flags, using the standard EQ..LE table. 1110 (AL) gives 1; 1111 gives 0 (never, no longer x).
- FlagWrite[g] = FlagW[g] & CondEx. Each flag group register loads ALUFlags on the next edge when its FlagWrite bit is set; otherwise it holds.
- CondExR <= CondEx on every edge, giving 1-cycle latency.
- RegWrite = RegW & CondExR; MemWrite = MemW & CondExR; PCWrite = (PCS & CondExR) | NextPC.
- FSM has two states, IDLE and ACTIVE.
- IDLE to ACTIVE: on InstrRetire & ITStart with 1 <= ITLen.
  - Latch ITFirstCond and ITMask.
  - count <= min(ITLen, IT_DEPTH); index <= 0; ITCond <= ITFirstCond.
- IDLE, ITLen=0: no transition; ITErr pulses.
- IDLE, ITLen > IT_DEPTH: clamp to IT_DEPTH; no error.
- ACTIVE, each InstrRetire:
  - count decrements and index increments.
  - If count reaches 0, go to IDLE and clear ITCond.
  - Otherwise ITCond <= {base[3:1], base[0] ^ ~mask[index+1]}.
- AL base: if ITFirstCond=1110, inversion is suppressed and ITCond stays 1110 for the whole block.
- Taken branch in ACTIVE: PCS & CondExR, or NextPC asserted outside fetch, is out of scope. A taken PCS on the same cycle as InstrRetire forces IDLE regardless of count.
- ITStart with InstrRetire while ACTIVE (nested IT): the retire is processed normally, the new block is ignored, and ITErr pulses for one cycle.
- InIT = (state == ACTIVE). ITCond and InIT change on the edge after InstrRetire.
- Reset mid-block: immediate return to IDLE on that edge; the remaining predicated instructions execute as unconditional (Cond field).

Decomposition:
- Shared package cond_pkg contains:
  - condition encodings COND_EQ..COND_AL and COND_NV;
  - flag bit index constants;
  - state enum it_state_t {IT_IDLE, IT_ACTIVE};
  - helper constant COND_INV_BIT=0.
- Sub-module cond_eval (4-bit cond, 4-bit flags to CondEx) is combinational and is instantiated once.
- Flag registers and the FSM stay inline.

Test Plan:
1. Plain mode: Flags=0100 (Z), Cond=0000, RegW=1 -> RegWrite=1 one cycle after evaluation. Same with Cond=0001 -> RegWrite=0.
2. Grouped flag write, FLAGW_GRP=2: FlagW=01, CondEx=1, ALUFlags=1111 from Flags=0000 -> Flags=0011 next edge. With Cond failing -> Flags unchanged.
3. IT block: ITFirstCond=0000, ITLen=3, ITMask=x01x (bit1=1, bit2=0), Z=1. Three retires give ITCond 0000, 0000, 0001 -> RegWrite 1,1,0. InIT drops after the third retire.
4. AL base: ITFirstCond=1110, ITMask all 0, ITLen=2 -> ITCond stays 1110 and both instructions write.
5. Errors: ITLen=0 in IDLE -> ITErr pulse, InIT stays 0. ITStart during ACTIVE -> ITErr pulse, count continues from the original block.
6. Reset asserted with count=2 in ACTIVE -> next edge InIT=0, Flags=0, CondExR=0. A following Cond=1110 instruction writes normally.
